// File: rtl/axi_lite_master_pkg.sv
// axi_lite_pkg: shared FSM states, default widths and response codes for axi_lite_master
package axi_lite_pkg;
    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_RESP_W  = 4;
    localparam int DEF_TIMEOUT = 16;
    localparam logic [3:0] RESP_OKAY   = 4'd0;
    localparam logic [3:0] RESP_SLVERR = 4'd2;
    typedef enum logic [2:0] {IDLE, AR, R, WA, B, RSP} state_t;
endpackage

// File: rtl/axi_lite_master_if.sv
// axi_lite_master_if: AR/R/AW/W/B channel bundle between the master and its slave
interface axi_lite_master_if #(
    parameter int ADDR_W = axi_lite_pkg::DEF_ADDR_W,
    parameter int DATA_W = axi_lite_pkg::DEF_DATA_W,
    parameter int RESP_W = axi_lite_pkg::DEF_RESP_W
);
    logic [ADDR_W-1:0] read_address;
    logic              AR_VALID;
    logic              AR_READY;
    logic [DATA_W-1:0] data_read;
    logic              R_VALID;
    logic              R_READY;
    logic [ADDR_W-1:0] write_address;
    logic              AW_VALID;
    logic              AW_READY;
    logic [DATA_W-1:0] write_data;
    logic              W_VALID;
    logic              W_READY;
    logic              B_VALID;
    logic [RESP_W-1:0] BRESPONSE;
    logic              B_READY;

    modport master (
        output read_address, AR_VALID, R_READY, write_address, AW_VALID, write_data, W_VALID, B_READY,
        input  AR_READY, data_read, R_VALID, AW_READY, W_READY, B_VALID, BRESPONSE
    );

    modport slave (
        input  read_address, AR_VALID, R_READY, write_address, AW_VALID, write_data, W_VALID, B_READY,
        output AR_READY, data_read, R_VALID, AW_READY, W_READY, B_VALID, BRESPONSE
    );
endinterface

// File: rtl/axi_lite_master_timeout.sv
// axi_lite_timeout: saturating per-phase wait counter used when AXIM_TIMEOUT_EN is defined
module axi_lite_timeout
    import axi_lite_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT
) (
    input  logic m_clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = LIMIT > 2 ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt;

    assign expired = cnt == CW'(LIMIT - 1);

    // Count wait cycles, parking at the limit so the flag stays up until cleared
    always_ff @(posedge m_clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && !expired) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI-Lite master; define AXIM_TIMEOUT_EN for per-phase timeout
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int RESP_W         = DEF_RESP_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic              m_clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [RESP_W-1:0] rsp_resp,
    output logic              rsp_error,
    axi_lite_master_if.master bus
);
    state_t state;
    logic   write_q;
    logic   ar_hs, aw_done, w_done, rd_fin, wr_fin, adv, timeout;

    assign cmd_ready = rst_n && state == IDLE;
    assign rsp_valid = state == RSP;
    assign ar_hs     = bus.AR_VALID && bus.AR_READY;
    assign aw_done   = !bus.AW_VALID || bus.AW_READY;
    assign w_done    = !bus.W_VALID || bus.W_READY;
    assign rd_fin    = (state == R || (state == AR && ar_hs)) && bus.R_VALID;
    assign wr_fin    = (state == B || (state == WA && aw_done && w_done)) && bus.B_VALID;
    assign adv       = state == AR ? ar_hs :
                       state == R  ? bus.R_VALID :
                       state == WA ? aw_done && w_done :
                       state == B  ? bus.B_VALID : 1'b1;

`ifdef AXIM_TIMEOUT_EN
    logic expired;

    axi_lite_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .m_clk   (m_clk),
        .rst_n   (rst_n),
        .clr     (adv),
        .en      (state != IDLE && state != RSP),
        .expired (expired)
    );

    assign timeout = expired && !adv;
`else
    assign timeout = 1'b0;
`endif

    // Sequencer: owns every channel output and the captured response; later assignments take priority
    always_ff @(posedge m_clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            write_q           <= 1'b0;
            bus.read_address  <= '0;
            bus.AR_VALID      <= 1'b0;
            bus.R_READY       <= 1'b0;
            bus.write_address <= '0;
            bus.write_data    <= '0;
            bus.AW_VALID      <= 1'b0;
            bus.W_VALID       <= 1'b0;
            bus.B_READY       <= 1'b0;
            rsp_write         <= 1'b0;
            rsp_rdata         <= '0;
            rsp_resp          <= '0;
            rsp_error         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    write_q <= cmd_write;
                    state   <= cmd_write ? WA : AR;
                    if (cmd_write) begin
                        bus.write_address <= cmd_addr;
                        bus.write_data    <= cmd_wdata;
                        bus.AW_VALID      <= 1'b1;
                        bus.W_VALID       <= 1'b1;
                        bus.B_READY       <= 1'b1;
                    end else begin
                        bus.read_address <= cmd_addr;
                        bus.AR_VALID     <= 1'b1;
                        bus.R_READY      <= 1'b1;
                    end
                end
                AR: if (ar_hs) begin
                    bus.AR_VALID <= 1'b0;
                    state        <= R;
                end
                WA: begin
                    bus.AW_VALID <= bus.AW_VALID && !bus.AW_READY;
                    bus.W_VALID  <= bus.W_VALID && !bus.W_READY;
                    if (aw_done && w_done) state <= B;
                end
                RSP: if (rsp_ready) state <= IDLE;
                default: ;
            endcase
            if (rd_fin || wr_fin) begin
                bus.R_READY <= 1'b0;
                bus.B_READY <= 1'b0;
                rsp_write   <= wr_fin;
                rsp_rdata   <= rd_fin ? bus.data_read : '0;
                rsp_resp    <= wr_fin ? bus.BRESPONSE : RESP_W'(RESP_OKAY);
                rsp_error   <= 1'b0;
                state       <= RSP;
            end
            if (timeout) begin
                bus.AR_VALID <= 1'b0;
                bus.R_READY  <= 1'b0;
                bus.AW_VALID <= 1'b0;
                bus.W_VALID  <= 1'b0;
                bus.B_READY  <= 1'b0;
                rsp_write    <= write_q;
                rsp_rdata    <= '0;
                rsp_resp     <= RESP_W'(RESP_SLVERR);
                rsp_error    <= 1'b1;
                state        <= RSP;
            end
        end
    end
endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
AXI-Lite master that turns single-beat user commands (read or write) into AXI-Lite channel transactions toward the 4-bit-address / 8-bit-data slave. It sits directly upstream of that slave, drives its AR/R/AW/W/B channels, and returns read data or write status on a valid/ready response port. One transaction is outstanding at a time.

Parameters:
ADDR_W, 4, address width on cmd_addr, read_address and write_address
DATA_W, 8, data width on cmd_wdata, write_data, data_read and rsp_rdata
RESP_W, 4, width of BRESPONSE and rsp_resp
TIMEOUT_CYCLES, 16, wait-cycle limit per channel phase (used only with AXIM_TIMEOUT_EN)

Ports:
m_clk  in  1  clock; all logic is rising-edge
rst_n  in  1  reset; asynchronous, active-low
cmd_valid  in  1  user command valid
cmd_ready  out  1  master accepts a command
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  user accepts the response
rsp_write  out  1  response belongs to a write
rsp_rdata  out  DATA_W  read data; 0 for writes
rsp_resp  out  RESP_W  write response code; 0 for reads
rsp_error  out  1  transaction aborted on timeout
read_address  out  ADDR_W  AR address
AR_VALID  out  1
AR_READY  in  1
data_read  in  DATA_W  R data
R_VALID  in  1
R_READY  out  1
write_address  out  ADDR_W  AW address
AW_VALID  out  1
AW_READY  in  1
write_data  out  DATA_W  W data
W_VALID  out  1
W_READY  in  1
B_VALID  in  1
BRESPONSE  in  RESP_W
B_READY  out  1

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All outputs are 0, including every *_VALID, *_READY, address, data and rsp field. cmd_ready is 1 once rst_n is high and the state is IDLE.
- A reset asserted mid-transaction drops all VALID/READY outputs immediately. The transaction is lost and no response is produced.
- A handshake occurs on a rising edge when VALID and READY are both 1.
- States:
  - IDLE:
    - cmd_ready=1.
    - On a cmd handshake, register addr, wdata and write; go to AR (read) or WA (write).
  - AR:
    - AR_VALID=1 and R_READY=1. read_address is held stable.
    - On the AR handshake, AR_VALID goes to 0 next cycle; go to R.
    - If R_VALID arrives in the same cycle as the AR handshake, capture data_read and go straight to RSP.
  - R:
    - R_READY=1.
    - On R_VALID, capture data_read into rsp_rdata, set rsp_resp=0, and go to RSP.
  - WA:
    - AW_VALID=1 and W_VALID=1 together.
    - Each VALID drops independently after its own handshake.
    - B_READY=1 from entry to WA.
    - When both handshakes are done, go to B.
    - If B_VALID is sampled in the same cycle as the last handshake, capture BRESPONSE and go to RSP.
  - B:
    - B_READY=1.
    - On B_VALID, capture BRESPONSE into rsp_resp, set rsp_rdata=0, and go to RSP.
  - RSP:
    - rsp_valid=1; rsp fields are stable.
    - On the rsp handshake, go to IDLE.
    - cmd_ready stays 0 until IDLE, so no back-to-back overlap.
- Latency (zero-wait slave, rsp_ready=1): cmd handshake at edge 0 → AR_VALID high in cycle 1 → R data in cycle 2 → rsp_valid in cycle 3. Writes take the same count.
- VALID outputs never depend combinationally on READY inputs. All channel outputs are registered.

Optional Feature:
AXIM_TIMEOUT_EN:
- Defined:
  - A wait counter clears on every state entry and increments each cycle spent in AR, R, WA or B.
  - On reaching TIMEOUT_CYCLES-1, all channel VALID/READY outputs drop next cycle.
  - The response then has rsp_error=1 and rsp_resp=4'd2; go to RSP.
- Undefined: no counter; rsp_error is tied to 0; the master waits indefinitely.

Decomposition:
- Package axi_lite_pkg holds:
  - the state enum (IDLE, AR, R, WA, B, RSP);
  - the default widths;
  - the response codes RESP_OKAY=0 and RESP_SLVERR=2.
- One natural sub-module, axi_lite_timeout: a saturating wait counter with clear/enable/expired signals, instantiated only under AXIM_TIMEOUT_EN.

Test Plan:
- Read addr 4'h5 from a reset-initialised slave (mem[5]=8'h55), rsp_ready=1 → rsp_valid 3 cycles after the cmd handshake; rsp_rdata=8'h55, rsp_write=0, rsp_error=0.
- Write 8'hA5 to 4'h3, then read 4'h3 → write response has rsp_write=1 and rsp_resp equal to the slave's BRESPONSE (4'd3); the read returns 8'hA5.
- Slave holds AW_READY=0 for 3 cycles while W_READY=1 → W_VALID drops after 1 cycle, AW_VALID stays high until AW_READY, then one response is produced.
- rsp_ready held low for 5 cycles → rsp fields stable and cmd_ready=0 throughout; next command accepted the cycle after the rsp handshake.
- rst_n pulsed low while in R → AR_VALID, R_READY and rsp_valid drop to 0 asynchronously; after release, cmd_ready=1 and no stale response appears.
- AXIM_TIMEOUT_EN with AR_READY tied 0 and TIMEOUT_CYCLES=16 → AR_VALID drops after 16 cycles; response has rsp_error=1 and rsp_resp=4'd2.
